// File: rtl/serial_bus_arbiter_if.sv
// Bus bundle between the arbiter, its requesters and the shared serial master.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface serial_bus_arbiter_if #(
    parameter int requester_count = 4,
    parameter int word_width      = 8,
    parameter int SS_width        = 1
);
    logic [requester_count-1:0]            req;
    logic [requester_count*word_width-1:0] req_data;
    logic [requester_count*SS_width-1:0]   req_ss;
    logic [requester_count-1:0]            grant;
    logic [requester_count-1:0]            done;
    logic [requester_count-1:0]            err;
    logic [word_width-1:0]                 rsp_data;
    logic                                  m_start;
    logic [word_width-1:0]                 m_data_out;
    logic [SS_width-1:0]                   m_ss;
    logic                                  m_busy;
    logic                                  m_done;
    logic [word_width-1:0]                 m_data_in;

    modport master (
        input  req, req_data, req_ss, m_busy, m_done, m_data_in,
        output grant, done, err, rsp_data, m_start, m_data_out, m_ss
    );

    modport slave (
        output req, req_data, req_ss, m_busy, m_done, m_data_in,
        input  grant, done, err, rsp_data, m_start, m_data_out, m_ss
    );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one serial master between requesters,
// with per-transaction watchdog abort. All outputs are registered.
module serial_bus_arbiter #(
    parameter int requester_count = 4,
    parameter int word_width      = 8,
    parameter int SS_width        = 1,
    parameter int timeout_width   = 8
) (
    input logic clk,
    input logic rst,
    serial_bus_arbiter_if.master bus
);
    localparam int IW = (requester_count > 1) ? $clog2(requester_count) : 1;
    // Compared before the increment so the abort lands after 2**tw-1 WAIT cycles.
    localparam logic [timeout_width-1:0] TMO_LAST = timeout_width'((2**timeout_width) - 2);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t                     state_q, state_d;
    logic [IW-1:0]              ptr_q, ptr_d;
    logic [IW-1:0]              owner_q, owner_d;
    logic [timeout_width-1:0]   timer_q, timer_d;
    logic [requester_count-1:0] grant_q, grant_d;
    logic [requester_count-1:0] done_q, done_d;
    logic [requester_count-1:0] err_q, err_d;
    logic [word_width-1:0]      rsp_q, rsp_d;
    logic                       m_start_q, m_start_d;
    logic [word_width-1:0]      m_data_q, m_data_d;
    logic [SS_width-1:0]        m_ss_q, m_ss_d;

    logic          found;
    logic [IW-1:0] win;
    int            idx;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < requester_count; k++) begin
            idx = (int'(ptr_q) + k) % requester_count;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        timer_d   = timer_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = '0;
        rsp_d     = rsp_q;
        m_start_d = 1'b0;
        m_data_d  = m_data_q;
        m_ss_d    = m_ss_q;
        case (state_q)
            IDLE: begin
                if (found && !bus.m_busy) begin
                    grant_d          = '0;
                    grant_d[win]     = 1'b1;
                    owner_d          = win;
                    m_data_d         = bus.req_data[int'(win)*word_width +: word_width];
                    m_ss_d           = bus.req_ss[int'(win)*SS_width +: SS_width];
                    m_start_d        = 1'b1;
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.m_done) begin
                    rsp_d   = bus.m_data_in;
                    done_d  = grant_q;
                    state_d = RELEASE;
                end else if (timer_q == TMO_LAST) begin
                    err_d   = grant_q;
                    state_d = RELEASE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RELEASE: begin
                grant_d = '0;
                ptr_d   = (int'(owner_q) == requester_count - 1) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            timer_q   <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rsp_q     <= '0;
            m_start_q <= 1'b0;
            m_data_q  <= '0;
            m_ss_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            timer_q   <= timer_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rsp_q     <= rsp_d;
            m_start_q <= m_start_d;
            m_data_q  <= m_data_d;
            m_ss_q    <= m_ss_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.rsp_data   = rsp_q;
    assign bus.m_start    = m_start_q;
    assign bus.m_data_out = m_data_q;
    assign bus.m_ss       = m_ss_q;
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter; completions are scoreboarded through a queue.
module tb_serial_bus_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 1;
    localparam int TW = 3;

    typedef struct {
        logic [N-1:0] owner;
        logic [W-1:0] rsp;
        bit           is_err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    logic [W-1:0] last_rsp = '0;

    serial_bus_arbiter_if #(.requester_count(N), .word_width(W), .SS_width(SW)) bus();

    serial_bus_arbiter #(.requester_count(N), .word_width(W), .SS_width(SW), .timeout_width(TW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input int widx, input string tag);
        int   cyc = 0;
        logic [N-1:0] eg;
        while (bus.grant === '0 && cyc < 40) begin
            step();
            cyc++;
        end
        eg = '0;
        eg[widx] = 1'b1;
        chk({tag, "_grant"}, 32'(bus.grant), 32'(eg));
        chk({tag, "_start"}, 32'(bus.m_start), 32'd1);
        chk({tag, "_mdata"}, 32'(bus.m_data_out), 32'(bus.req_data[widx*W +: W]));
        chk({tag, "_mss"}, 32'(bus.m_ss), 32'(bus.req_ss[widx*SW +: SW]));
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_done"}, 32'(bus.done), e.is_err ? 32'd0 : 32'(e.owner));
            chk({tag, "_err"}, 32'(bus.err), e.is_err ? 32'(e.owner) : 32'd0);
            chk({tag, "_rsp"}, 32'(bus.rsp_data), 32'(e.rsp));
            chk({tag, "_grant_rel"}, 32'(bus.grant), 32'(e.owner));
        end
        step();
        chk({tag, "_grant_low"}, 32'(bus.grant), 32'd0);
    endtask

    // Called at the negedge where grant/m_start first appear; m_done is sampled
    // in the d-th WAIT cycle.
    task automatic complete(input int d, input logic [W-1:0] data, input string tag);
        logic [N-1:0] own = bus.grant;
        logic [W-1:0] md  = bus.m_data_out;
        for (int i = 0; i < d; i++) begin
            step();
            if (i == 0) chk({tag, "_start_pulse"}, 32'(bus.m_start), 32'd0);
        end
        chk({tag, "_mdata_stable"}, 32'(bus.m_data_out), 32'(md));
        bus.m_done    = 1'b1;
        bus.m_data_in = data;
        sb.push_back('{owner: own, rsp: data, is_err: 1'b0});
        last_rsp = data;
        step();
        bus.m_done    = 1'b0;
        bus.m_data_in = 8'h00;
        check_resp(tag);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_data  = 32'hD4C3_B2A5;
        bus.req_ss    = 4'b0101;
        bus.m_busy    = 1'b0;
        bus.m_done    = 1'b0;
        bus.m_data_in = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_start", 32'(bus.m_start), 32'd0);
        chk("rst_rsp", 32'(bus.rsp_data), 32'd0);
        chk("rst_mdata", 32'(bus.m_data_out), 32'd0);

        // Single transaction, requester 0; req_data changes mid-flight.
        bus.req = 4'b0001;
        step();
        wait_grant(0, "t1");
        bus.req_data = 32'hD4C3_B2FF;
        complete(5, 8'h3C, "t1");
        bus.req = '0;
        bus.req_data = 32'hD4C3_B2A5;

        // Round robin from ptr=0 with all requesting.
        rst = 1'b1; step(); rst = 1'b0;
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(i % N, $sformatf("rr%0d", i));
            complete(3, 8'h10 + 8'(i), $sformatf("rr%0d", i));
        end
        bus.req = '0;

        // Wrap: ptr=1, req=0101 -> idx2; then ptr=3 -> idx0.
        bus.req = 4'b0101;
        wait_grant(2, "wrap_a");
        complete(2, 8'h55, "wrap_a");
        wait_grant(0, "wrap_b");
        complete(2, 8'h66, "wrap_b");
        bus.req = '0;

        // Busy master blocks the grant.
        bus.m_busy = 1'b1;
        bus.req    = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i % 3 == 0) begin
                chk("busy_grant", 32'(bus.grant), 32'd0);
                chk("busy_start", 32'(bus.m_start), 32'd0);
            end
        end
        bus.m_busy = 1'b0;
        step();
        chk("busy_release_grant", 32'(bus.grant), 32'b0010);
        wait_grant(1, "busy");
        complete(1, 8'h77, "busy");
        bus.req = '0;

        // Timeout: ptr=2, req=1000 -> idx3, no m_done.
        bus.req = 4'b1000;
        wait_grant(3, "tmo");
        for (int i = 0; i < 7; i++) step();
        chk("tmo_no_err_early", 32'(bus.err), 32'd0);
        sb.push_back('{owner: 4'b1000, rsp: last_rsp, is_err: 1'b1});
        step();
        check_resp("tmo");
        bus.req = '0;

        // m_done on the last watchdog cycle counts as done.
        bus.req = 4'b0001;
        wait_grant(0, "corner");
        complete(7, 8'h9E, "corner");
        bus.req = '0;

        // Move ptr to 2, then reset during WAIT of idx3.
        bus.req = 4'b0010;
        wait_grant(1, "pre_rst");
        complete(2, 8'h21, "pre_rst");
        bus.req = 4'b1000;
        wait_grant(3, "mid_rst");
        step(); step();
        bus.req = 4'b0101;
        rst = 1'b1;
        step();
        chk("mid_rst_grant", 32'(bus.grant), 32'd0);
        chk("mid_rst_start", 32'(bus.m_start), 32'd0);
        chk("mid_rst_rsp", 32'(bus.rsp_data), 32'd0);
        last_rsp = '0;
        rst = 1'b0;
        bus.m_done    = 1'b1;
        bus.m_data_in = 8'hEE;
        step();
        bus.m_done    = 1'b0;
        bus.m_data_in = 8'h00;
        chk("late_done_ignored", 32'(bus.done), 32'd0);
        wait_grant(0, "post_rst");
        complete(3, 8'h42, "post_rst");
        bus.req = '0;

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end
endmodule
